// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared definitions for the RAM port arbiter: the arbiter state encoding,
//   the default geometry (32 x 8 RAM) and the default write-streak limit.
package ram_port_arbiter_pkg;

  localparam int ARB_AW            = 5;
  localparam int ARB_DW            = 8;
  localparam int ARB_MAX_WR_STREAK = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } arb_state_t;

  // Counter width able to hold 0..max_streak inclusive.
  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// arb_streak_counter
//   Saturating count of write grants issued while a read is waiting.
//   Ports:
//     Clock     - system clock
//     Resetn    - asynchronous active-low reset
//     i_wr_gnt  - write granted this cycle
//     i_rd_gnt  - read granted this cycle
//     i_rd_req  - read request pending this cycle
//     o_at_max  - streak has reached MAX_WR_STREAK; the read must win next
module arb_streak_counter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MAX_WR_STREAK = ARB_MAX_WR_STREAK
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_wr_gnt,
  input  logic i_rd_gnt,
  input  logic i_rd_req,
  output logic o_at_max
);

  localparam int             SW      = streak_width(MAX_WR_STREAK);
  localparam logic [SW-1:0]  MAX_VAL = SW'(MAX_WR_STREAK);

  logic [SW-1:0] r_streak;

  // A read that goes away (granted or withdrawn) forgets the streak, so a
  // returning read always waits for a full MAX_WR_STREAK writes.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_streak <= '0;
    end else if (i_rd_gnt || !i_rd_req) begin
      r_streak <= '0;
    end else if (i_wr_gnt && (r_streak != MAX_VAL)) begin
      r_streak <= r_streak + SW'(1);
    end
  end

  assign o_at_max = (r_streak == MAX_VAL);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM between a write requester and a read
//   requester. Writes have priority, but a pending read is guaranteed a
//   grant after MAX_WR_STREAK consecutive writes.
//
//   state  | meaning
//   IDLE   | nothing granted last cycle
//   WRITE  | write granted last cycle
//   READ   | read granted last cycle; RAM output is valid now (rd_valid)
//
//   Ports:
//     Clock, Resetn             - clock, asynchronous active-low reset
//     wr_req/wr_addr/wr_data    - write request, held until wr_gnt
//     wr_gnt                    - write committed at this edge
//     rd_req/rd_addr            - read request, held until rd_gnt
//     rd_gnt                    - read address captured at this edge
//     rd_valid/rd_data          - read result, one cycle after rd_gnt
//     ram_address/ram_data/ram_wren/ram_q - RAM port (registered address)
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW            = ARB_AW,
  parameter int DW            = ARB_DW,
  parameter int MAX_WR_STREAK = ARB_MAX_WR_STREAK
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          w_wr_gnt;
  logic          w_rd_gnt;
  logic          w_at_max;
  logic [AW-1:0] r_addr_hold;
  logic [DW-1:0] r_data_hold;

  arb_streak_counter #(
    .MAX_WR_STREAK (MAX_WR_STREAK)
  ) u_streak (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .i_wr_gnt (w_wr_gnt),
    .i_rd_gnt (w_rd_gnt),
    .i_rd_req (rd_req),
    .o_at_max (w_at_max)
  );

  // Grants are gated by Resetn directly so nothing is granted while reset
  // is held, even though the requests may be high.
  always_comb begin
    w_wr_gnt    = 1'b0;
    w_rd_gnt    = 1'b0;
    w_state_nxt = ST_IDLE;
    if (Resetn) begin
      if (wr_req && !(rd_req && w_at_max)) begin
        w_wr_gnt    = 1'b1;
        w_state_nxt = ST_WRITE;
      end else if (rd_req) begin
        w_rd_gnt    = 1'b1;
        w_state_nxt = ST_READ;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Keep the RAM port quiet between grants: the address and data stay at
  // whatever was last granted instead of following the requesters.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else if (w_wr_gnt) begin
      r_addr_hold <= wr_addr;
      r_data_hold <= wr_data;
    end else if (w_rd_gnt) begin
      r_addr_hold <= rd_addr;
    end
  end

  assign wr_gnt      = w_wr_gnt;
  assign rd_gnt      = w_rd_gnt;
  assign ram_wren    = w_wr_gnt;
  assign ram_address = w_wr_gnt ? wr_addr : (w_rd_gnt ? rd_addr : r_addr_hold);
  assign ram_data    = w_wr_gnt ? wr_data : r_data_hold;

  // READ state is exactly "read granted at the last edge", which is when
  // the RAM presents the data; reset drops it immediately.
  assign rd_valid = (r_state == ST_READ);
  assign rd_data  = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW    = ARB_AW;
  localparam int DW    = ARB_DW;
  localparam int MAXS  = ARB_MAX_WR_STREAK;
  localparam int DEPTH = 1 << AW;

  logic          Clock;
  logic          Resetn;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  ram_port_arbiter #(
    .AW            (AW),
    .DW            (DW),
    .MAX_WR_STREAK (MAXS)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Single-port RAM with registered address: q shows the addressed word
  // one cycle later; a write is visible to a read in the following cycle.
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge Clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            w;
    bit            r;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            chk_data;
  } cyc_exp_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_exp_t;

  cyc_exp_t q_cyc[$];
  rd_exp_t  q_rd[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endfunction

  // Reference model: requester state plus the rules of arbitration.
  bit            wr_pend, rd_pend;
  logic [AW-1:0] wa_cur, ra_cur;
  logic [DW-1:0] wd_cur;
  int            m_streak;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_data;
  logic [DW-1:0] m_mem [0:DEPTH-1];

  task automatic step(input bit want_w, input bit want_r,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra);
    cyc_exp_t e;
    rd_exp_t  rx;
    bit gw, gr, rq;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    if (!want_w) wr_pend = 1'b0;
    else if (!wr_pend) begin wr_pend = 1'b1; wa_cur = wa; wd_cur = wd; end
    if (!want_r) rd_pend = 1'b0;
    else if (!rd_pend) begin rd_pend = 1'b1; ra_cur = ra; end
    wr_req = wr_pend; wr_addr = wa_cur; wr_data = wd_cur;
    rd_req = rd_pend; rd_addr = ra_cur;
    rq = rd_pend;
    // a waiting read wins once it has watched MAXS writes go by
    gw = wr_pend && !(rd_pend && m_streak >= MAXS);
    gr = rd_pend && !gw;
    e.cyc = cyc; e.w = gw; e.r = gr; e.chk_data = !gr;
    if (gw) begin
      e.addr = wa_cur; e.data = wd_cur;
      m_mem[wa_cur] = wd_cur;
      m_last_addr = wa_cur; m_last_data = wd_cur;
      wr_pend = 1'b0;
    end else if (gr) begin
      e.addr = ra_cur; e.data = m_last_data;
      m_last_addr = ra_cur;
      rx.cyc = cyc + 1; rx.data = m_mem[ra_cur];
      q_rd.push_back(rx);
      rd_pend = 1'b0;
    end else begin
      e.addr = m_last_addr; e.data = m_last_data;
    end
    q_cyc.push_back(e);
    if (!rq || gr) m_streak = 0;
    else if (gw) m_streak = m_streak + 1;
  endtask

  task automatic do_reset(input int n, input bit force_req);
    cyc_exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      if (i == 0) begin
        Resetn = 1'b0;
        q_rd.delete();
        m_streak = 0; m_last_addr = '0; m_last_data = '0;
        if (force_req) begin
          if (!wr_pend) begin
            wr_pend = 1'b1;
            wa_cur = AW'($urandom_range(0, DEPTH-1));
            wd_cur = DW'($urandom_range(0, 255));
          end
          if (!rd_pend) begin
            rd_pend = 1'b1;
            ra_cur = AW'($urandom_range(0, DEPTH-1));
          end
        end
      end
      wr_req = wr_pend; wr_addr = wa_cur; wr_data = wd_cur;
      rd_req = rd_pend; rd_addr = ra_cur;
      e.cyc = cyc; e.w = 1'b0; e.r = 1'b0; e.addr = '0; e.data = '0; e.chk_data = 1'b1;
      q_cyc.push_back(e);
    end
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  initial begin
    cyc_exp_t e;
    rd_exp_t  rx;
    forever begin
      @(negedge Clock);
      if (q_cyc.size() > 0 && q_cyc[0].cyc == cyc) begin
        e = q_cyc.pop_front();
        chk("wr_gnt", 32'(wr_gnt), 32'(e.w));
        chk("rd_gnt", 32'(rd_gnt), 32'(e.r));
        chk("ram_wren", 32'(ram_wren), 32'(e.w));
        chk("ram_address", 32'(ram_address), 32'(e.addr));
        if (e.chk_data) chk("ram_data", 32'(ram_data), 32'(e.data));
      end
      if (rd_valid) begin
        if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
          rx = q_rd.pop_front();
          chk("rd_data", 32'(rd_data), 32'(rx.data));
        end else begin
          chk("rd_valid_spurious", 32'(rd_valid), 32'(0));
        end
      end else begin
        chk("rd_data_idle", 32'(rd_data), 32'(0));
        if (q_rd.size() > 0 && q_rd[0].cyc <= cyc) begin
          chk("rd_valid_missing", 32'(rd_valid), 32'(1));
          void'(q_rd.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    Resetn = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    wr_pend = 1'b0; rd_pend = 1'b0;
    wa_cur = '0; wd_cur = '0; ra_cur = '0;
    m_streak = 0; m_last_addr = '0; m_last_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end

    do_reset(3, 1'b0);

    // write then read back the same word
    step(1'b1, 1'b0, 5'h03, 8'hA5, 5'h00);
    step(1'b0, 1'b1, 5'h00, 8'h00, 5'h03);
    step(1'b0, 1'b0, 5'h00, 8'h00, 5'h00);
    step(1'b0, 1'b0, 5'h00, 8'h00, 5'h00);

    // both held high: four writes, then the read
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b1, AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)),
           AW'($urandom_range(0, DEPTH-1)));

    // read withdrawn after two writes, then back: streak starts over
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)),
           AW'($urandom_range(0, DEPTH-1)));
    step(1'b1, 1'b0, AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)), 5'h00);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)),
           AW'($urandom_range(0, DEPTH-1)));
    step(1'b0, 1'b0, 5'h00, 8'h00, 5'h00);
    step(1'b0, 1'b0, 5'h00, 8'h00, 5'h00);

    // read immediately after write to the same address
    step(1'b1, 1'b0, 5'h07, 8'h3C, 5'h00);
    step(1'b0, 1'b1, 5'h00, 8'h00, 5'h07);
    step(1'b0, 1'b0, 5'h00, 8'h00, 5'h00);

    // reset the cycle after a read grant, with both requests held high
    step(1'b0, 1'b1, 5'h00, 8'h00, 5'h11);
    do_reset(3, 1'b1);
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)),
           AW'($urandom_range(0, DEPTH-1)));

    // random traffic; requesters never withdraw a pending request
    for (int i = 0; i < 400; i++) begin
      wa = AW'($urandom_range(0, DEPTH-1));
      wd = DW'($urandom_range(0, 255));
      ra = AW'($urandom_range(0, DEPTH-1));
      if (i == 200) do_reset(2, 1'b0);
      step(wr_pend || ($urandom_range(0, 99) < 60),
           rd_pend || ($urandom_range(0, 99) < 50), wa, wd, ra);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'h00, 8'h00, 5'h00);
    @(negedge Clock); #1;
    chk("rd_queue_drained", 32'(q_rd.size()), 32'(0));
    chk("cyc_queue_drained", 32'(q_cyc.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter AW, default 5: RAM address width (32 words).
REQ-002 Parameter DW, default 8: RAM data width.
REQ-003 Parameter MAX_WR_STREAK, default 4: maximum consecutive write grants while a read is pending.
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  asynchronous, active-low reset.
REQ-006 wr_req  input  1  write requester holds high until granted.
REQ-007 wr_addr  input  AW  write address; stable while wr_req high.
REQ-008 wr_data  input  DW  write data; stable while wr_req high.
REQ-009 wr_gnt  output  1  one-cycle pulse: the write is committed at this clock edge.
REQ-010 rd_req  input  1  read requester (address scanner) holds high until granted.
REQ-011 rd_addr  input  AW  read address; stable while rd_req high.
REQ-012 rd_gnt  output  1  one-cycle pulse: the read address is captured at this edge.
REQ-013 rd_valid  output  1  high for exactly one cycle, the cycle after rd_gnt.
REQ-014 rd_data  output  DW  read result; meaningful only while rd_valid is high.
REQ-015 ram_address  output  AW  single-port RAM address (RAM registers it internally).
REQ-016 ram_data  output  DW  RAM write data.
REQ-017 ram_wren  output  1  RAM write enable.
REQ-018 ram_q  input  DW  RAM output; valid one cycle after the address edge.

Function
REQ-019 Decision is combinational on the current requests and state: at most one of wr_gnt/rd_gnt is high in any cycle.
REQ-020 A grant is issued in the same cycle as the request is seen, and only if that request is high.
REQ-021 The FSM has three states: IDLE (no grant last cycle), WRITE (write granted last cycle) and READ (read granted last cycle).
REQ-022 Writes have priority: with both requests high, wr_gnt is issued unless streak == MAX_WR_STREAK, in which case rd_gnt is issued.
REQ-023 streak is a counter of width clog2(MAX_WR_STREAK+1): it increments on each wr_gnt while rd_req is high and saturates at MAX_WR_STREAK.
REQ-024 streak clears to 0 on any rd_gnt, or in any cycle in which rd_req is low.
REQ-025 On wr_gnt: ram_address=wr_addr, ram_data=wr_data, ram_wren=1.
REQ-026 On rd_gnt: ram_address=rd_addr, ram_wren=0.
REQ-027 When idle: ram_wren=0, ram_address holds the last granted address, and ram_data holds the last write data.
REQ-028 rd_valid is a register: it is set to rd_gnt on every edge.
REQ-029 rd_data = ram_q while rd_valid=1, and 0 otherwise.
REQ-030 Back-to-back reads are allowed: one grant per cycle, each with its own rd_valid pulse.
REQ-031 A read following a write to the same address in the previous cycle returns the new data.
REQ-032 Requests held high are re-arbitrated every cycle; each grant consumes exactly one transaction.

Reset
REQ-033 Resetn low immediately sets: state=IDLE, streak=0, rd_valid=0, held ram_address=0, held ram_data=0.
REQ-034 During reset, wr_gnt=0, rd_gnt=0 and ram_wren=0, regardless of the requests.
REQ-035 A read granted just before reset asserts produces no rd_valid pulse.
REQ-036 Arbitration resumes on the first rising edge after Resetn deasserts.

Structure
REQ-037 A shared package holds the state enum (IDLE/WRITE/READ) and the defaults AW=5, DW=8 and MAX_WR_STREAK=4.
REQ-038 There is one sub-module, arb_streak_counter, containing the saturating streak counter; everything else is flat.

Verification
REQ-039 Reset release, write only: wr_req with addr 5'h03, data 8'hA5 -> wr_gnt in the same cycle, ram_wren=1, ram_address=3, ram_data=A5.
REQ-040 Read only: rd_req with addr 5'h03 after the write above -> rd_gnt, then next cycle rd_valid=1 and rd_data=8'hA5.
REQ-041 wr_req and rd_req both held high continuously -> grant pattern W,W,W,W,R repeating; rd_valid follows each R by one cycle.
REQ-042 rd_req drops after 2 write grants, then returns -> streak restarts from 0, so 4 more writes are granted before the read.
REQ-043 Write to addr 7 (data 8'h3C) then read of addr 7 on the next cycle -> rd_data=8'h3C.
REQ-044 Resetn pulsed low in the cycle after rd_gnt -> rd_valid=0 at once, streak=0, no grants until release.
